dual_issue_ctrl: RTL and testbench
==================================

# dual_issue_ctrl

Registered control unit for the dual-issue MIPS datapath: decodes an ALU-slot opcode (slot 0) and a memory-slot opcode (slot 1) into ID/EX control signals. It splits intra-pair dependent pairs across two cycles, holds decode while a memory access is outstanding (with timeout), and squashes on branch flush. It sits between the decode stage and the ID/EX register and replaces the purely combinational decoder.

## Interface
- REG_W, 5: register-address width.
- MEM_TIMEOUT, 255: max MEMWAIT cycles before abort; counter width $clog2(MEM_TIMEOUT+1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  decode holds a valid instruction pair.
- opcode0, opcode1  in  6 each  slot-0 / slot-1 opcodes.
- rs0, rt0, rd0, rs1, rt1  in  REG_W each  register fields.
- flush  in  1  branch taken in EX; squash current pair.
- mem_ready  in  1  data memory completed the outstanding lw/sw.
- branch_eq, branch_ne, alusrc, regdst, regwrite  out  1 each  slot-0 controls (registered).
- aluop  out  2  slot-0 ALU op (registered).
- memread, memwrite, regwrite1  out  1 each  slot-1 controls (registered).
- ex_valid  out  1  registered; at least one slot issued this cycle.
- stall  out  1  combinational; decode must hold its pair next cycle.
- mem_err  out  1  registered one-cycle pulse on memory timeout.
- illegal  out  1  registered one-cycle pulse on undecodable pair (see Configuration).

## Operation
- Slot-0 decode: 000000 add (regdst=1, regwrite=1, aluop=10); 001000 addi (regdst=0, alusrc=1, regwrite=1, aluop=00); 000100 beq (branch_eq=1, aluop=10, regwrite=0); 000101 bne (branch_ne=1, aluop=10, regwrite=0).
- Slot-1 decode: 100011 lw (memread=1, regwrite1=1); 101011 sw (memwrite=1); 000000 nop.
- Bubble: every registered control output 0, aluop=00, ex_valid=0.
- Slot-0 destination d0 = addi ? rt0 : rd0. Dependency DEP = valid_in, slot 0 writes, d0!=0, and (slot 1 lw/sw with rs1==d0, or slot 1 sw with rt1==d0).
- FSM states: RUN, SPLIT, MEMWAIT; reset -> RUN, timeout counter 0.
- RUN, flush=1: bubble, stall=0, stay RUN.
- RUN, valid_in=0: bubble, stall=0.
- RUN, DEP: issue slot 0 only (slot-1 outputs 0), stall=1, -> SPLIT.
- RUN, no DEP: issue both slots, stall=0; -> MEMWAIT if slot 1 is lw/sw, else stay RUN.
- SPLIT: issue slot 1 only from the held inputs (slot-0 outputs bubble), stall=0; -> MEMWAIT if lw/sw, else RUN. flush in SPLIT: bubble, slot 1 dropped, -> RUN.
- MEMWAIT: bubble, stall=1, counter increments. mem_ready=1 -> RUN next cycle; stall stays 1 that cycle. Counter reaching MEM_TIMEOUT without mem_ready -> mem_err pulse, -> RUN. flush does not leave MEMWAIT; the access is older than the branch.
- Counter clears on every entry to MEMWAIT.

## Timing
- Controls, ex_valid, mem_err, illegal: one-cycle latency from the sampled inputs; stall is same-cycle.
- Reset: all registered outputs 0 the cycle after rst is sampled high; stall=0 while in RUN. rst mid-SPLIT/MEMWAIT aborts to RUN with no mem_err.
- mem_ready sampled only in MEMWAIT; ignored elsewhere.
- Minimum memory-op penalty: 1 MEMWAIT cycle (mem_ready high on first MEMWAIT cycle).

## Configuration
- DUAL_ISSUE_ILLEGAL_EN defined: opcode0 outside {add, addi, beq, bne} or opcode1 outside {nop, lw, sw} issues a bubble for the whole pair, pulses illegal, with no SPLIT or MEMWAIT; stall=0.
- Undefined: unknown opcode0 decodes as add, unknown opcode1 as nop; illegal tied 0.

## Test plan
- rst=1 for 2 cycles -> all outputs 0, stall=0, state RUN.
- add(rd0=3) + lw(rs1=3) -> cycle 1: regwrite=1, memread=0, stall=1; cycle 2: memread=1, regwrite1=1, regwrite=0, stall=0; then MEMWAIT.
- addi + sw(rs1=4), d0=5, mem_ready high 3 cycles later -> both slots issue together; stall=1 for 3 cycles, RUN on the 4th.
- lw with mem_ready never high, MEM_TIMEOUT=4 -> 4 bubble cycles, mem_err pulses once, return to RUN.
- SPLIT pending and flush=1 -> bubble, memread=0, RUN, stall=0.
- opcode0=6'b111111 with macro defined -> bubble plus illegal=1 for 1 cycle; macro undefined -> regwrite=1, regdst=1, aluop=10.

Source files
------------

// File: rtl/dual_issue_ctrl.sv
// Registered ID/EX control for the dual-issue pair: slot 0 is ALU/branch, slot 1 is lw/sw/nop.
// Define DUAL_ISSUE_ILLEGAL_EN to trap undecodable opcode pairs; otherwise they decode as add/nop.
module dual_issue_ctrl #(
   parameter int unsigned REG_W       = 5,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [5:0]       opcode0,
   input  logic [5:0]       opcode1,
   input  logic [REG_W-1:0] rs0,
   input  logic [REG_W-1:0] rt0,
   input  logic [REG_W-1:0] rd0,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rt1,
   input  logic             flush,
   input  logic             mem_ready,
   output logic             branch_eq,
   output logic             branch_ne,
   output logic             alusrc,
   output logic             regdst,
   output logic             regwrite,
   output logic [1:0]       aluop,
   output logic             memread,
   output logic             memwrite,
   output logic             regwrite1,
   output logic             ex_valid,
   output logic             stall,
   output logic             mem_err,
   output logic             illegal
);

   localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [5:0] OpAdd  = 6'b000000;
   localparam logic [5:0] OpAddi = 6'b001000;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpBne  = 6'b000101;
   localparam logic [5:0] OpNop  = 6'b000000;
   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;

   typedef enum logic [1:0] {StRun, StSplit, StMemWait} state_e;

   typedef struct packed {
      logic       branch_eq;
      logic       branch_ne;
      logic       alusrc;
      logic       regdst;
      logic       regwrite;
      logic [1:0] aluop;
      logic       memread;
      logic       memwrite;
      logic       regwrite1;
      logic       ex_valid;
      logic       mem_err;
      logic       illegal;
   } ctl_t;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            hold_lw_q, hold_lw_d;
   logic            hold_sw_q, hold_sw_d;
   ctl_t            ctl_q, ctl_d;

   // rs0 feeds the register file only; nothing in the control path depends on it.
   logic unused_rs0;
   assign unused_rs0 = ^rs0;

   // Slot-0 opcode classes
   logic is_add, is_addi, is_beq, is_bne, add_like, op0_known, s0_writes;
   // Slot-1 opcode classes
   logic is_lw, is_sw, is_nop, op1_known, s1_mem;
   logic             illegal_pair;
   logic [REG_W-1:0] d0;
   logic             dep;
   ctl_t             slot0_ctl, slot1_ctl, split_ctl;

   always_comb begin
      is_add    = (opcode0 == OpAdd);
      is_addi   = (opcode0 == OpAddi);
      is_beq    = (opcode0 == OpBeq);
      is_bne    = (opcode0 == OpBne);
      op0_known = is_add | is_addi | is_beq | is_bne;
      is_lw     = (opcode1 == OpLw);
      is_sw     = (opcode1 == OpSw);
      is_nop    = (opcode1 == OpNop);
      op1_known = is_lw | is_sw | is_nop;
      s1_mem    = is_lw | is_sw;
`ifdef DUAL_ISSUE_ILLEGAL_EN
      add_like     = is_add;
      illegal_pair = !(op0_known && op1_known);
`else
      // Unknown slot-0 opcodes fall back to add; unknown slot-1 opcodes already act as nop.
      add_like     = !(is_addi | is_beq | is_bne);
      illegal_pair = 1'b0;
`endif
      s0_writes = add_like | is_addi;
      d0        = is_addi ? rt0 : rd0;
      dep       = valid_in && s0_writes && (d0 != '0) &&
                  ((s1_mem && (rs1 == d0)) || (is_sw && (rt1 == d0)));
   end

   always_comb begin
      slot0_ctl           = '0;
      slot0_ctl.branch_eq = is_beq;
      slot0_ctl.branch_ne = is_bne;
      slot0_ctl.alusrc    = is_addi;
      slot0_ctl.regdst    = add_like;
      slot0_ctl.regwrite  = s0_writes;
      slot0_ctl.aluop     = is_addi ? 2'b00 : 2'b10;
      slot0_ctl.ex_valid  = 1'b1;

      slot1_ctl           = '0;
      slot1_ctl.memread   = is_lw;
      slot1_ctl.memwrite  = is_sw;
      slot1_ctl.regwrite1 = is_lw;
      slot1_ctl.ex_valid  = 1'b1;

      split_ctl           = '0;
      split_ctl.memread   = hold_lw_q;
      split_ctl.memwrite  = hold_sw_q;
      split_ctl.regwrite1 = hold_lw_q;
      split_ctl.ex_valid  = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_lw_d = hold_lw_q;
      hold_sw_d = hold_sw_q;
      ctl_d     = '0;
      stall     = 1'b0;
      unique case (state_q)
         StRun: begin
            cnt_d = '0;
            if (flush || !valid_in) begin
               ctl_d = '0;
            end else if (illegal_pair) begin
               ctl_d.illegal = 1'b1;
            end else if (dep) begin
               ctl_d     = slot0_ctl;
               stall     = 1'b1;
               hold_lw_d = is_lw;
               hold_sw_d = is_sw;
               state_d   = StSplit;
            end else begin
               ctl_d = slot0_ctl | slot1_ctl;
               if (s1_mem) state_d = StMemWait;
            end
         end
         StSplit: begin
            cnt_d = '0;
            if (flush) begin
               state_d = StRun;
            end else begin
               ctl_d   = split_ctl;
               state_d = (hold_lw_q || hold_sw_q) ? StMemWait : StRun;
            end
         end
         StMemWait: begin
            // flush is ignored here: the outstanding access predates the branch.
            stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (mem_ready) begin
               state_d = StRun;
               cnt_d   = '0;
            end else if (cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
               ctl_d.mem_err = 1'b1;
               state_d       = StRun;
               cnt_d         = '0;
            end
         end
         default: begin
            state_d = StRun;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StRun;
         cnt_q     <= '0;
         hold_lw_q <= 1'b0;
         hold_sw_q <= 1'b0;
         ctl_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_lw_q <= hold_lw_d;
         hold_sw_q <= hold_sw_d;
         ctl_q     <= ctl_d;
      end
   end

   assign branch_eq = ctl_q.branch_eq;
   assign branch_ne = ctl_q.branch_ne;
   assign alusrc    = ctl_q.alusrc;
   assign regdst    = ctl_q.regdst;
   assign regwrite  = ctl_q.regwrite;
   assign aluop     = ctl_q.aluop;
   assign memread   = ctl_q.memread;
   assign memwrite  = ctl_q.memwrite;
   assign regwrite1 = ctl_q.regwrite1;
   assign ex_valid  = ctl_q.ex_valid;
   assign mem_err   = ctl_q.mem_err;
   assign illegal   = ctl_q.illegal;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed bench for dual_issue_ctrl with MEM_TIMEOUT=4; expected control words are hand-built.
module tb_dual_issue_ctrl;

   localparam int unsigned REG_W       = 5;
   localparam int unsigned MEM_TIMEOUT = 4;

   localparam logic [5:0] OpAdd  = 6'b000000;
   localparam logic [5:0] OpAddi = 6'b001000;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpBne  = 6'b000101;
   localparam logic [5:0] OpNop  = 6'b000000;
   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;

   logic             clk = 1'b0;
   logic             rst;
   logic             valid_in;
   logic [5:0]       opcode0, opcode1;
   logic [REG_W-1:0] rs0, rt0, rd0, rs1, rt1;
   logic             flush, mem_ready;
   logic             branch_eq, branch_ne, alusrc, regdst, regwrite;
   logic [1:0]       aluop;
   logic             memread, memwrite, regwrite1, ex_valid, stall, mem_err, illegal;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dual_issue_ctrl #(
      .REG_W      (REG_W),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_in (valid_in),
      .opcode0  (opcode0),
      .opcode1  (opcode1),
      .rs0      (rs0),
      .rt0      (rt0),
      .rd0      (rd0),
      .rs1      (rs1),
      .rt1      (rt1),
      .flush    (flush),
      .mem_ready(mem_ready),
      .branch_eq(branch_eq),
      .branch_ne(branch_ne),
      .alusrc   (alusrc),
      .regdst   (regdst),
      .regwrite (regwrite),
      .aluop    (aluop),
      .memread  (memread),
      .memwrite (memwrite),
      .regwrite1(regwrite1),
      .ex_valid (ex_valid),
      .stall    (stall),
      .mem_err  (mem_err),
      .illegal  (illegal)
   );

   logic [12:0] ctl;
   assign ctl = {branch_eq, branch_ne, alusrc, regdst, regwrite, aluop,
                 memread, memwrite, regwrite1, ex_valid, mem_err, illegal};

   function automatic logic [12:0] pk(input logic beq, bne, asrc, rdst, rw, input logic [1:0] aop,
                                      input logic mr, mw, rw1, exv, merr, ill);
      return {beq, bne, asrc, rdst, rw, aop, mr, mw, rw1, exv, merr, ill};
   endfunction

   localparam logic [12:0] Bubble = '0;
   logic [12:0] c_add, c_add_lw, c_lw, c_addi_sw, c_addi, c_sw, c_beq, c_bne_lw, c_merr, c_ill;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] o0, input logic [5:0] o1,
                        input logic [REG_W-1:0] s0, input logic [REG_W-1:0] t0,
                        input logic [REG_W-1:0] d0, input logic [REG_W-1:0] s1,
                        input logic [REG_W-1:0] t1);
      valid_in = v;
      opcode0  = o0;
      opcode1  = o1;
      rs0      = s0;
      rt0      = t0;
      rd0      = d0;
      rs1      = s1;
      rt1      = t1;
   endtask

   initial begin
      c_add     = pk(0, 0, 0, 1, 1, 2'b10, 0, 0, 0, 1, 0, 0);
      c_add_lw  = pk(0, 0, 0, 1, 1, 2'b10, 1, 0, 1, 1, 0, 0);
      c_lw      = pk(0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 1, 0, 0);
      c_addi_sw = pk(0, 0, 1, 0, 1, 2'b00, 0, 1, 0, 1, 0, 0);
      c_addi    = pk(0, 0, 1, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0);
      c_sw      = pk(0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0);
      c_beq     = pk(1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1, 0, 0);
      c_bne_lw  = pk(0, 1, 0, 0, 0, 2'b10, 1, 0, 1, 1, 0, 0);
      c_merr    = pk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
      c_ill     = pk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);

      rst = 1'b1;
      flush = 1'b0;
      mem_ready = 1'b0;
      drive(0, OpNop, OpNop, 0, 0, 0, 0, 0);
      tick();
      tick();
      check_eq("reset_ctl", 32'(ctl), 32'(Bubble));
      rst = 1'b0;
      #1 check_eq("reset_stall", 32'(stall), 0);

      // add r3 + lw rs1=r3: split across two cycles, then one MEMWAIT cycle
      drive(1, OpAdd, OpLw, 1, 2, 3, 3, 0);
      #1 check_eq("dep_stall", 32'(stall), 1);
      tick();
      check_eq("dep_slot0", 32'(ctl), 32'(c_add));
      check_eq("split_stall", 32'(stall), 0);
      tick();
      check_eq("dep_slot1", 32'(ctl), 32'(c_lw));
      valid_in = 1'b0;
      #1 check_eq("mw_stall", 32'(stall), 1);
      mem_ready = 1'b1;
      tick();
      check_eq("mw_bubble", 32'(ctl), 32'(Bubble));
      mem_ready = 1'b0;
      #1 check_eq("mw_exit", 32'(stall), 0);

      // addi rt0=5 + sw rs1=4: no dependency, ready arrives on third MEMWAIT cycle
      drive(1, OpAddi, OpSw, 1, 5, 0, 4, 6);
      #1 check_eq("pair_stall", 32'(stall), 0);
      tick();
      check_eq("addi_sw", 32'(ctl), 32'(c_addi_sw));
      valid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 check_eq("sw_wait_stall", 32'(stall), 1);
         mem_ready = (i == 2);
         tick();
         check_eq("sw_wait_ctl", 32'(ctl), 32'(Bubble));
      end
      mem_ready = 1'b0;
      #1 check_eq("sw_wait_exit", 32'(stall), 0);

      // addi rt0=7 + sw rt1=7: store-data dependency
      drive(1, OpAddi, OpSw, 1, 7, 0, 1, 7);
      #1 check_eq("swdata_dep_stall", 32'(stall), 1);
      tick();
      check_eq("swdata_slot0", 32'(ctl), 32'(c_addi));
      tick();
      check_eq("swdata_slot1", 32'(ctl), 32'(c_sw));
      valid_in = 1'b0;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      #1 check_eq("swdata_exit", 32'(stall), 0);

      // flush while SPLIT is pending drops slot 1
      drive(1, OpAdd, OpLw, 1, 2, 3, 3, 0);
      #1 check_eq("flush_dep_stall", 32'(stall), 1);
      tick();
      check_eq("flush_slot0", 32'(ctl), 32'(c_add));
      flush = 1'b1;
      #1 check_eq("flush_split_stall", 32'(stall), 0);
      tick();
      check_eq("split_flush", 32'(ctl), 32'(Bubble));
      flush = 1'b0;
      valid_in = 1'b0;
      #1 check_eq("flush_run", 32'(stall), 0);
      tick();
      check_eq("invalid_bubble", 32'(ctl), 32'(Bubble));

      // lw with no ready: timeout after 4 MEMWAIT cycles; flush mid-wait is ignored
      drive(1, OpAdd, OpLw, 1, 2, 2, 9, 0);
      tick();
      check_eq("to_issue", 32'(ctl), 32'(c_add_lw));
      valid_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         flush = (i == 1);
         #1 check_eq("to_stall", 32'(stall), 1);
         tick();
         check_eq("to_ctl", 32'(ctl), (i == 3) ? 32'(c_merr) : 32'(Bubble));
      end
      flush = 1'b0;
      #1 check_eq("to_exit", 32'(stall), 0);
      tick();
      check_eq("merr_once", 32'(ctl), 32'(Bubble));

      // branches never write, so bne r3 + lw rs1=r3 is independent
      drive(1, OpBeq, OpNop, 1, 2, 3, 0, 0);
      #1 check_eq("beq_stall", 32'(stall), 0);
      tick();
      check_eq("beq", 32'(ctl), 32'(c_beq));
      drive(1, OpBne, OpLw, 3, 3, 3, 3, 0);
      #1 check_eq("bne_stall", 32'(stall), 0);
      tick();
      check_eq("bne_lw", 32'(ctl), 32'(c_bne_lw));
      valid_in = 1'b0;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;

      // flush in RUN squashes a dependent pair without splitting
      drive(1, OpAdd, OpLw, 1, 2, 3, 3, 0);
      flush = 1'b1;
      #1 check_eq("run_flush_stall", 32'(stall), 0);
      tick();
      check_eq("run_flush_ctl", 32'(ctl), 32'(Bubble));
      flush = 1'b0;

      // mem_ready high while in RUN must not short-circuit the next wait
      drive(1, OpAdd, OpLw, 1, 2, 2, 9, 0);
      mem_ready = 1'b1;
      tick();
      check_eq("rdy_issue", 32'(ctl), 32'(c_add_lw));
      valid_in = 1'b0;
      #1 check_eq("rdy_ignored_stall", 32'(stall), 1);
      tick();
      check_eq("rdy_exit_stall", 32'(stall), 0);
      mem_ready = 1'b0;

      // unknown slot-0 opcode
      drive(1, 6'b111111, OpNop, 1, 2, 4, 0, 0);
      #1 check_eq("unk_stall", 32'(stall), 0);
      tick();
`ifdef DUAL_ISSUE_ILLEGAL_EN
      check_eq("unk_illegal", 32'(ctl), 32'(c_ill));
`else
      check_eq("unk_as_add", 32'(ctl), 32'(c_add));
`endif
      valid_in = 1'b0;
      tick();
      check_eq("unk_once", 32'(ctl), 32'(Bubble));

      // reset during MEMWAIT returns to RUN with no mem_err
      drive(1, OpAdd, OpLw, 1, 2, 2, 9, 0);
      tick();
      valid_in = 1'b0;
      #1 check_eq("rst_mw_stall", 32'(stall), 1);
      rst = 1'b1;
      tick();
      check_eq("rst_mw_ctl", 32'(ctl), 32'(Bubble));
      rst = 1'b0;
      #1 check_eq("rst_mw_run", 32'(stall), 0);
      tick();
      check_eq("rst_mw_no_err", 32'(ctl), 32'(Bubble));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
